// File: rtl/thread_scheduler_pkg.sv
// Shared pipeline definitions for the fetch front end.
//   n_threads     : number of hardware threads (power of two, >= 2)
//   threadid_t    : hardware thread id, carried IF -> ID -> EX
//   sched_state_t : per-thread fetch scheduling state (READY / WAIT)
package common;

  localparam int n_threads = 4;

  typedef logic [$clog2(n_threads)-1:0] threadid_t;

  typedef enum logic {
    READY = 1'b0,
    WAIT  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/thread_scheduler_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// by scanning upward from last+1, wrapping modulo N.
//   req   : request mask, one bit per requester
//   last  : index granted most recently
//   found : at least one request bit is set
//   idx   : granted index (meaningful only when found=1)
// N must be a power of two so the index arithmetic wraps for free.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0]   start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   pos;
  logic           hit;

  // Rotate so that bit 0 of rot is requester last+1, priority-encode the
  // lowest set bit, then add the rotation back to get the real index.
  always_comb begin
    start = last + W'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
    pos   = '0;
    hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit && rot[i]) begin
        pos = W'(i);
        hit = 1'b1;
      end
    end
    found = |req;
    idx   = start + pos;
  end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin fetch-thread scheduler in front of the IF stage.
// Threads that report an iTLB/iCache miss are parked in WAIT until the
// matching fill arrives; every unstalled cycle the next eligible thread
// (READY and enabled) after the last pick is chosen.
//   clk, rst     : clock, synchronous active-high reset
//   thread_en    : per-thread enable; disabled threads are never picked
//   stall        : freezes the pick outputs and round-robin pointer
//   miss_valid/miss_itlb/miss_thread : miss report from IF
//   fill_valid/fill_thread           : fill completion from memory/TLB
//   sched_valid/sched_thread         : registered pick for next fetch
//   ready_mask   : registered per-thread READY flags
//   wait_itlb    : per-thread "parked on iTLB miss" flag
module thread_scheduler
  import common::*;
#(
  parameter int N_THREADS = common::n_threads,
  parameter int TID_W     = $clog2(N_THREADS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_THREADS-1:0] thread_en,
  input  logic                 stall,
  input  logic                 miss_valid,
  input  logic                 miss_itlb,
  input  logic [TID_W-1:0]     miss_thread,
  input  logic                 fill_valid,
  input  logic [TID_W-1:0]     fill_thread,
  output logic                 sched_valid,
  output logic [TID_W-1:0]     sched_thread,
  output logic [N_THREADS-1:0] ready_mask,
  output logic [N_THREADS-1:0] wait_itlb
);

  sched_state_t           thr_state_p0 [N_THREADS];
  sched_state_t           thr_state_p1 [N_THREADS];
  logic [N_THREADS-1:0]   itlb_p0;
  logic [N_THREADS-1:0]   itlb_p1;
  logic [N_THREADS-1:0]   ready_p0;
  logic [N_THREADS-1:0]   eligible_p0;
  logic [TID_W-1:0]       last_p1;
  logic                   pick_found_p0;
  logic [TID_W-1:0]       pick_idx_p0;

  // ---- stage p0: per-thread next state, eligibility and pick ----
  // A fill is applied first, then a miss; so a same-cycle fill+miss on a
  // waiting thread leaves it waiting with the newer miss type.
  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      thr_state_p0[t] = thr_state_p1[t];
      itlb_p0[t]      = itlb_p1[t];
      if (fill_valid && (fill_thread == TID_W'(t)) && (thr_state_p1[t] == WAIT)) begin
        thr_state_p0[t] = READY;
        itlb_p0[t]      = 1'b0;
      end
      if (miss_valid && (miss_thread == TID_W'(t)) && (thr_state_p0[t] == READY)) begin
        thr_state_p0[t] = WAIT;
        itlb_p0[t]      = miss_itlb;
      end
      ready_p0[t] = (thr_state_p0[t] == READY);
    end
    eligible_p0 = ready_p0 & thread_en;
  end

  rr_picker #(
    .N (N_THREADS),
    .W (TID_W)
  ) u_picker (
    .req   (eligible_p0),
    .last  (last_p1),
    .found (pick_found_p0),
    .idx   (pick_idx_p0)
  );

  // ---- stage p1: registered thread state (updates even when stalled) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_THREADS; t++) begin
        thr_state_p1[t] <= READY;
      end
      itlb_p1 <= '0;
    end else begin
      for (int t = 0; t < N_THREADS; t++) begin
        thr_state_p1[t] <= thr_state_p0[t];
      end
      itlb_p1 <= itlb_p0;
    end
  end

  // ---- stage p1: registered pick and round-robin pointer ----
  // last resets to the top index so the first pick scans from thread 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sched_valid  <= 1'b0;
      sched_thread <= '0;
      last_p1      <= TID_W'(N_THREADS - 1);
    end else if (!stall) begin
      sched_valid <= pick_found_p0;
      if (pick_found_p0) begin
        sched_thread <= pick_idx_p0;
        last_p1      <= pick_idx_p0;
      end
    end
  end

  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      ready_mask[t] = (thr_state_p1[t] == READY);
    end
    wait_itlb = itlb_p1;
  end

endmodule

// File: tb/tb_thread_scheduler.sv
module tb_thread_scheduler;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] thread_en;
  logic         stall;
  logic         miss_valid;
  logic         miss_itlb;
  logic [W-1:0] miss_thread;
  logic         fill_valid;
  logic [W-1:0] fill_thread;
  logic         sched_valid;
  logic [W-1:0] sched_thread;
  logic [N-1:0] ready_mask;
  logic [N-1:0] wait_itlb;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  thread_scheduler #(.N_THREADS(N), .TID_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .thread_en    (thread_en),
    .stall        (stall),
    .miss_valid   (miss_valid),
    .miss_itlb    (miss_itlb),
    .miss_thread  (miss_thread),
    .fill_valid   (fill_valid),
    .fill_thread  (fill_thread),
    .sched_valid  (sched_valid),
    .sched_thread (sched_thread),
    .ready_mask   (ready_mask),
    .wait_itlb    (wait_itlb)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pick(input string tag, input logic v, input logic [W-1:0] t);
    chk({tag, ".valid"}, 32'(sched_valid), 32'(v));
    chk({tag, ".thread"}, 32'(sched_thread), 32'(t));
  endtask

  task automatic miss(input logic [W-1:0] t, input logic it);
    miss_valid = 1'b1; miss_thread = t; miss_itlb = it;
  endtask

  task automatic fill(input logic [W-1:0] t);
    fill_valid = 1'b1; fill_thread = t;
  endtask

  task automatic idle();
    miss_valid = 1'b0; fill_valid = 1'b0; miss_itlb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; thread_en = 4'b1111; stall = 1'b0;
    miss_valid = 1'b0; miss_itlb = 1'b0; miss_thread = '0;
    fill_valid = 1'b0; fill_thread = '0;
    tick(); tick();
    // Reset state
    chk_pick("rst", 1'b0, 2'd0);
    chk("rst.ready", 32'(ready_mask), 32'hF);
    chk("rst.witlb", 32'(wait_itlb), 32'h0);

    // 1: plain rotation
    rst = 1'b0;
    tick(); chk_pick("rr0", 1'b1, 2'd0);
    tick(); chk_pick("rr1", 1'b1, 2'd1);
    tick(); chk_pick("rr2", 1'b1, 2'd2);
    tick(); chk_pick("rr3", 1'b1, 2'd3);
    tick(); chk_pick("rr4", 1'b1, 2'd0);

    // 2: thread 2 iTLB miss, then fill
    miss(2'd2, 1'b1);
    tick(); chk_pick("m2a", 1'b1, 2'd1);
    chk("m2.ready", 32'(ready_mask), 32'hB);
    chk("m2.witlb", 32'(wait_itlb), 32'h4);
    idle();
    tick(); chk_pick("m2b", 1'b1, 2'd3);
    tick(); chk_pick("m2c", 1'b1, 2'd0);
    tick(); chk_pick("m2d", 1'b1, 2'd1);
    fill(2'd2);
    tick(); chk_pick("f2", 1'b1, 2'd2);
    chk("f2.ready", 32'(ready_mask), 32'hF);
    idle();

    // 3: every thread misses in turn -> bubbles, then fill thread 1
    miss(2'd0, 1'b0); tick(); chk_pick("all0", 1'b1, 2'd3);
    miss(2'd1, 1'b0); tick(); chk_pick("all1", 1'b1, 2'd2);
    miss(2'd2, 1'b0); tick(); chk_pick("all2", 1'b1, 2'd3);
    miss(2'd3, 1'b0); tick(); chk_pick("all3", 1'b0, 2'd3);
    idle();
    tick(); chk_pick("bub", 1'b0, 2'd3);
    chk("bub.ready", 32'(ready_mask), 32'h0);
    fill(2'd1);
    tick(); chk_pick("f1", 1'b1, 2'd1);
    chk("f1.ready", 32'(ready_mask), 32'h2);
    idle();

    // 4: same-cycle fill+miss on waiting thread 3; fill on READY thread
    fill(2'd3); miss(2'd3, 1'b1);
    tick(); chk_pick("fm3", 1'b1, 2'd1);
    chk("fm3.ready", 32'(ready_mask), 32'h2);
    chk("fm3.witlb", 32'(wait_itlb), 32'h8);
    idle();
    fill(2'd0);
    tick(); chk_pick("f0", 1'b1, 2'd0);
    chk("f0.ready", 32'(ready_mask), 32'h3);
    fill(2'd0);
    tick(); chk_pick("f0r", 1'b1, 2'd1);
    chk("f0r.ready", 32'(ready_mask), 32'h3);
    fill(2'd2); tick(); chk_pick("f2b", 1'b1, 2'd2);
    fill(2'd3); tick(); chk_pick("f3b", 1'b1, 2'd3);
    chk("f3b.ready", 32'(ready_mask), 32'hF);
    chk("f3b.witlb", 32'(wait_itlb), 32'h0);
    idle();

    // 5: stall while thread 1 misses
    stall = 1'b1; miss(2'd1, 1'b0);
    tick(); chk_pick("st0", 1'b1, 2'd3);
    chk("st0.ready", 32'(ready_mask), 32'hD);
    idle();
    tick(); chk_pick("st1", 1'b1, 2'd3);
    tick(); chk_pick("st2", 1'b1, 2'd3);
    stall = 1'b0;
    tick(); chk_pick("us0", 1'b1, 2'd0);
    tick(); chk_pick("us1", 1'b1, 2'd2);
    fill(2'd1);
    tick(); chk_pick("us2", 1'b1, 2'd3);
    idle();
    tick(); chk_pick("us3", 1'b1, 2'd0);
    tick(); chk_pick("us4", 1'b1, 2'd1);

    // 6: partial enable, then reset while threads wait
    thread_en = 4'b0101;
    tick(); chk_pick("en0", 1'b1, 2'd2);
    tick(); chk_pick("en1", 1'b1, 2'd0);
    tick(); chk_pick("en2", 1'b1, 2'd2);
    tick(); chk_pick("en3", 1'b1, 2'd0);
    miss(2'd2, 1'b1); tick(); chk_pick("en4", 1'b1, 2'd0);
    miss(2'd0, 1'b0); tick(); chk_pick("en5", 1'b0, 2'd0);
    idle();
    chk("en5.ready", 32'(ready_mask), 32'hA);
    chk("en5.witlb", 32'(wait_itlb), 32'h4);
    rst = 1'b1;
    tick(); chk_pick("rst2", 1'b0, 2'd0);
    chk("rst2.ready", 32'(ready_mask), 32'hF);
    chk("rst2.witlb", 32'(wait_itlb), 32'h0);
    rst = 1'b0; thread_en = 4'b1111; fill(2'd2);
    tick(); chk_pick("post", 1'b1, 2'd0);
    chk("post.ready", 32'(ready_mask), 32'hF);
    idle();
    tick(); chk_pick("post1", 1'b1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
